// File: rtl/frame_buffer_pkg.sv
// Shared types, default geometry and bank-selection helper for the triple frame buffer.
package frame_buffer_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned WIDTH_DEF  = 160;
   localparam int unsigned HEIGHT_DEF = 120;

   typedef logic [1:0] bank_t;

   // Lowest bank index that is neither a nor b.
   function automatic bank_t free_bank(input bank_t a, input bank_t b);
      if (a != 2'd0 && b != 2'd0) return 2'd0;
      if (a != 2'd1 && b != 2'd1) return 2'd1;
      return 2'd2;
   endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port RAM: one write port, one registered read port, write-first on collision.
module fb_ram #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned WORDS  = 24,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [WORDS];
   logic [DATA_W-1:0] rdata_q, rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = (we && waddr == raddr) ? wdata : mem_q[raddr];
   end

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/triple_frame_buffer.sv
// Triple-buffered frame store: writer fills a free bank while the reader displays a stable one.
module triple_frame_buffer import frame_buffer_pkg::*; #(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned WIDTH  = WIDTH_DEF,
   parameter int unsigned HEIGHT = HEIGHT_DEF,
   localparam int unsigned DEPTH  = WIDTH * HEIGHT,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   input  logic              wr_sof,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_sof,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic [1:0]        display_bank,
   output logic              frame_done,
   output logic              frame_drop,
   output logic              short_frame,
   output logic              wr_overflow
);

   localparam int unsigned PHYS_W = $clog2(3 * DEPTH);

   function automatic logic [PHYS_W-1:0] phys(input bank_t b, input logic [ADDR_W-1:0] i);
      return PHYS_W'(b) * PHYS_W'(DEPTH) + PHYS_W'(i);
   endfunction

   bank_t             write_bank_q, write_bank_d, latest_bank_q, latest_bank_d;
   bank_t             display_bank_q, display_bank_d;
   logic              fresh_q, fresh_d, synced_q, synced_d;
   logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
   logic              frame_done_q, frame_done_d, frame_drop_q, frame_drop_d;
   logic              short_frame_q, short_frame_d, wr_overflow_q, wr_overflow_d;
   logic              rd_valid_q, rd_valid_d, rd_zero_q, rd_zero_d;
   logic              wr_accept, wr_last, rd_in_range;
   logic [ADDR_W-1:0] wr_eff_idx;
   logic [DATA_W-1:0] ram_rdata;

   always_comb begin
      wr_accept   = wr_valid && (wr_sof || synced_q);
      wr_eff_idx  = wr_sof ? '0 : wr_idx_q;
      wr_last     = wr_accept && (wr_eff_idx == ADDR_W'(DEPTH - 1));
      rd_in_range = 32'(rd_addr) < DEPTH;

      write_bank_d   = write_bank_q;
      latest_bank_d  = latest_bank_q;
      display_bank_d = display_bank_q;
      fresh_d        = fresh_q;
      synced_d       = synced_q;
      wr_idx_d       = wr_idx_q;

      frame_done_d  = wr_last;
      frame_drop_d  = wr_last && fresh_q;
      short_frame_d = wr_valid && wr_sof && synced_q && (wr_idx_q != '0);
      wr_overflow_d = wr_valid && !wr_accept;
      rd_valid_d    = rd_en;
      rd_zero_d     = !(rd_en && rd_in_range);

      if (wr_accept) begin
         synced_d = 1'b1;
         wr_idx_d = wr_eff_idx + ADDR_W'(1);
      end
      if (rd_sof && fresh_q) begin
         display_bank_d = latest_bank_q;
         fresh_d        = 1'b0;
      end
      if (wr_last) begin
         synced_d      = 1'b0;
         wr_idx_d      = '0;
         latest_bank_d = write_bank_q;
         // A coincident rd_sof takes the just-completed frame, freeing the old display bank.
         if (rd_sof) begin
            display_bank_d = write_bank_q;
            fresh_d        = 1'b0;
            write_bank_d   = free_bank(write_bank_q, write_bank_q);
         end else begin
            fresh_d      = 1'b1;
            write_bank_d = free_bank(write_bank_q, display_bank_q);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         write_bank_q   <= 2'd0;
         latest_bank_q  <= 2'd1;
         display_bank_q <= 2'd1;
         fresh_q        <= 1'b0;
         synced_q       <= 1'b0;
         wr_idx_q       <= '0;
         frame_done_q   <= 1'b0;
         frame_drop_q   <= 1'b0;
         short_frame_q  <= 1'b0;
         wr_overflow_q  <= 1'b0;
         rd_valid_q     <= 1'b0;
         rd_zero_q      <= 1'b1;
      end else begin
         write_bank_q   <= write_bank_d;
         latest_bank_q  <= latest_bank_d;
         display_bank_q <= display_bank_d;
         fresh_q        <= fresh_d;
         synced_q       <= synced_d;
         wr_idx_q       <= wr_idx_d;
         frame_done_q   <= frame_done_d;
         frame_drop_q   <= frame_drop_d;
         short_frame_q  <= short_frame_d;
         wr_overflow_q  <= wr_overflow_d;
         rd_valid_q     <= rd_valid_d;
         rd_zero_q      <= rd_zero_d;
      end
   end

   // Read uses display_bank_d so an rd_en alongside rd_sof sees the newly latched bank.
   fb_ram #(
      .DATA_W(DATA_W),
      .WORDS (3 * DEPTH),
      .ADDR_W(PHYS_W)
   ) u_ram (
      .clk  (clk),
      .we   (wr_accept && !rst),
      .waddr(phys(write_bank_q, wr_eff_idx)),
      .wdata(wr_data),
      .re   (rd_en && rd_in_range),
      .raddr(phys(display_bank_d, rd_addr)),
      .rdata(ram_rdata)
   );

   assign rd_data      = rd_zero_q ? '0 : ram_rdata;
   assign rd_valid     = rd_valid_q;
   assign display_bank = display_bank_q;
   assign frame_done   = frame_done_q;
   assign frame_drop   = frame_drop_q;
   assign short_frame  = short_frame_q;
   assign wr_overflow  = wr_overflow_q;

endmodule

// File: tb/tb_triple_frame_buffer.sv
// Directed bench for triple_frame_buffer (4x2 main instance, 5x1 instance for out-of-range reads).
module tb_triple_frame_buffer;

   logic       clk = 1'b0;
   logic       rst, wr_valid, wr_sof, rd_sof, rd_en;
   logic [7:0] wr_data, rd_data;
   logic [2:0] rd_addr;
   logic       rd_valid, frame_done, frame_drop, short_frame, wr_overflow;
   logic [1:0] display_bank;
   logic [3:0] pulses;

   logic       rst2, wv2, ws2, rs2, re2, rv2, fd2, fdr2, sf2, wo2;
   logic [7:0] wd2, rdd2;
   logic [2:0] ra2;
   logic [1:0] db2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;
   assign pulses = {frame_done, frame_drop, short_frame, wr_overflow};

   triple_frame_buffer #(.DATA_W(8), .WIDTH(4), .HEIGHT(2)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_sof(wr_sof), .wr_data(wr_data),
      .rd_sof(rd_sof), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_valid(rd_valid), .display_bank(display_bank), .frame_done(frame_done),
      .frame_drop(frame_drop), .short_frame(short_frame), .wr_overflow(wr_overflow)
   );

   triple_frame_buffer #(.DATA_W(8), .WIDTH(5), .HEIGHT(1)) dut2 (
      .clk(clk), .rst(rst2), .wr_valid(wv2), .wr_sof(ws2), .wr_data(wd2),
      .rd_sof(rs2), .rd_en(re2), .rd_addr(ra2), .rd_data(rdd2),
      .rd_valid(rv2), .display_bank(db2), .frame_done(fd2),
      .frame_drop(fdr2), .short_frame(sf2), .wr_overflow(wo2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic sof, input logic [7:0] d);
      wr_valid = 1'b1;
      wr_sof   = sof;
      wr_data  = d;
      tick();
      wr_valid = 1'b0;
      wr_sof   = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a);
      rd_en   = 1'b1;
      rd_addr = a;
      tick();
      rd_en   = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; wr_valid = 1'b0; wr_sof = 1'b0; wr_data = 8'h00;
      rd_sof = 1'b0; rd_en = 1'b0; rd_addr = 3'd0;
      rst2 = 1'b1; wv2 = 1'b0; ws2 = 1'b0; wd2 = 8'h00; rs2 = 1'b0; re2 = 1'b0; ra2 = 3'd0;
      tick();
      tick();
      rst = 1'b0; rst2 = 1'b0;

      chk("rst_display_bank", 32'(display_bank), 1);
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_rd_data", 32'(rd_data), 0);
      chk("rst_pulses", 32'(pulses), 0);

      // Unsynced pixels are discarded.
      for (int i = 0; i < 3; i++) begin
         push(1'b0, 8'hAA);
         chk("unsynced_overflow", 32'(pulses), 'h1);
      end

      // First full frame into bank 0.
      for (int i = 0; i < 8; i++) begin
         push(i == 0, 8'(8'h10 + i));
         chk("f0_pulses", 32'(pulses), (i == 7) ? 'h8 : 'h0);
      end
      rd_sof = 1'b1;
      tick();
      rd_sof = 1'b0;
      chk("f0_display_bank", 32'(display_bank), 0);
      chk("f0_pulse_cleared", 32'(pulses), 0);
      for (int i = 0; i < 8; i++) begin
         rd(3'(i));
         chk("f0_rd_valid", 32'(rd_valid), 1);
         chk("f0_rd_data", 32'(rd_data), 32'(8'h10 + i));
      end
      tick();
      chk("f0_rd_valid_idle", 32'(rd_valid), 0);

      // Short frame: 5 pixels then a new sof into bank 2.
      for (int i = 0; i < 5; i++) begin
         push(i == 0, 8'(8'h20 + i));
         chk("short_pre_pulses", 32'(pulses), 0);
      end
      for (int i = 0; i < 8; i++) begin
         push(i == 0, 8'(8'h30 + i));
         chk("short_pulses", 32'(pulses), (i == 0) ? 'h2 : ((i == 7) ? 'h8 : 'h0));
      end

      // Second unread frame into bank 1 replaces the fresh one.
      for (int i = 0; i < 8; i++) begin
         push(i == 0, 8'(8'h40 + i));
         chk("drop_pulses", 32'(pulses), (i == 7) ? 'hC : 'h0);
      end
      push(1'b0, 8'hEE);
      chk("post_frame_overflow", 32'(pulses), 'h1);
      rd_sof = 1'b1;
      rd(3'd0);
      rd_sof = 1'b0;
      chk("drop_display_bank", 32'(display_bank), 1);
      chk("drop_rd_sof_data", 32'(rd_data), 'h40);
      for (int i = 1; i < 8; i++) begin
         rd(3'(i));
         chk("drop_rd_data", 32'(rd_data), 32'(8'h40 + i));
      end

      // Completion coincident with rd_sof: bank 2 displayed, writer moves to bank 0.
      for (int i = 0; i < 7; i++) push(i == 0, 8'(8'h50 + i));
      rd_sof = 1'b1;
      push(1'b0, 8'h57);
      rd_sof = 1'b0;
      chk("coinc_pulses", 32'(pulses), 'h8);
      chk("coinc_display_bank", 32'(display_bank), 2);
      // Write the next frame while reading the displayed one.
      for (int i = 0; i < 8; i++) begin
         wr_valid = 1'b1; wr_sof = (i == 0); wr_data = 8'(8'h60 + i);
         rd_en = 1'b1; rd_addr = 3'(i);
         tick();
         chk("coinc_rd_data", 32'(rd_data), 32'(8'h50 + i));
      end
      wr_valid = 1'b0; wr_sof = 1'b0; rd_en = 1'b0;
      chk("coinc_w_done", 32'(frame_done), 1);
      rd_sof = 1'b1;
      rd(3'd3);
      rd_sof = 1'b0;
      chk("coinc_next_bank", 32'(display_bank), 0);
      chk("coinc_next_data", 32'(rd_data), 'h63);

      // Reset in the middle of a frame.
      for (int i = 0; i < 4; i++) push(i == 0, 8'(8'h70 + i));
      rst = 1'b1; wr_valid = 1'b1; wr_data = 8'h74; rd_en = 1'b1; rd_addr = 3'd0;
      tick();
      rst = 1'b0; wr_valid = 1'b0; rd_en = 1'b0;
      chk("midrst_display_bank", 32'(display_bank), 1);
      chk("midrst_rd_valid", 32'(rd_valid), 0);
      chk("midrst_rd_data", 32'(rd_data), 0);
      chk("midrst_pulses", 32'(pulses), 0);
      for (int i = 0; i < 8; i++) push(i == 0, 8'(8'h80 + i));
      chk("midrst_frame_pulses", 32'(pulses), 'h8);
      rd_sof = 1'b1;
      rd(3'd0);
      rd_sof = 1'b0;
      chk("midrst_bank0", 32'(display_bank), 0);
      chk("midrst_rd0", 32'(rd_data), 'h80);
      rd(3'd7);
      chk("midrst_rd7", 32'(rd_data), 'h87);

      // Out-of-range read addresses on the 5-pixel instance.
      for (int i = 0; i < 5; i++) begin
         wv2 = 1'b1; ws2 = (i == 0); wd2 = 8'(8'hA0 + i);
         tick();
         chk("oob_frame_done", 32'(fd2), (i == 4) ? 1 : 0);
      end
      wv2 = 1'b0; ws2 = 1'b0;
      rs2 = 1'b1; re2 = 1'b1; ra2 = 3'd4;
      tick();
      rs2 = 1'b0;
      chk("oob_display_bank", 32'(db2), 0);
      chk("oob_last_data", 32'(rdd2), 'hA4);
      ra2 = 3'd5;
      tick();
      chk("oob5_valid", 32'(rv2), 1);
      chk("oob5_data", 32'(rdd2), 0);
      ra2 = 3'd7;
      tick();
      chk("oob7_data", 32'(rdd2), 0);
      re2 = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
